// File: rtl/matvec_sequencer_if.sv
// matvec_sequencer_if: bundles every non-clock/reset signal of the dense-layer
// sequencer.
//   master : the sequencer side. It drives the control status, the ram_reader
//            request, the vector index, the multiply/accumulate IP inputs and
//            the row results.
//   slave  : the environment side. It drives start/config, read data, vector
//            data and the IP results.
interface matvec_sequencer_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
);
    // control
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  in_len;
    logic [LEN_WIDTH-1:0]  out_len;
    logic                  busy;
    logic                  done;
    // ram_reader read port
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    // input vector register file
    logic [LEN_WIDTH-1:0]  vec_idx;
    logic [DATA_WIDTH-1:0] vec_data;
    // fp16 multiply IP
    logic                  mul_valid;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic                  mul_res_valid;
    logic [DATA_WIDTH-1:0] mul_res;
    // fp16 accumulator IP
    logic                  acc_valid;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  acc_last;
    logic                  acc_res_valid;
    logic [DATA_WIDTH-1:0] acc_res;
    logic                  acc_res_last;
    // row results
    logic                  out_valid;
    logic [LEN_WIDTH-1:0]  out_idx;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  start, base_addr, in_len, out_len, rd_valid, rd_data, vec_data,
               mul_res_valid, mul_res, acc_res_valid, acc_res, acc_res_last,
        output busy, done, rd_req, rd_addr, vec_idx, mul_valid, mul_a, mul_b,
               acc_valid, acc_data, acc_last, out_valid, out_idx, out_data
    );

    modport slave (
        output start, base_addr, in_len, out_len, rd_valid, rd_data, vec_data,
               mul_res_valid, mul_res, acc_res_valid, acc_res, acc_res_last,
        input  busy, done, rd_req, rd_addr, vec_idx, mul_valid, mul_a, mul_b,
               acc_valid, acc_data, acc_last, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/matvec_sequencer.sv
// matvec_sequencer: sequences one dense layer,
//   out[r] = sum_c W[base + r*M + c] * vec[c].
// Weights are fetched one word at a time. Each weight/vector pair is issued to
// the fp16 multiply IP. Products are forwarded through one register stage to
// the fp16 accumulator IP, with tlast on every M-th product. One result is
// emitted per accumulator tlast.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : matvec_sequencer_if.master (control, read port, vector index,
//           IP streams, row results)
module matvec_sequencer #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input logic                 clk,
    input logic                 reset,
    matvec_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, FINISH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  m_q, m_d, n_q, n_d;
    logic [LEN_WIDTH-1:0]  row_q, row_d, col_q, col_d;
    logic [LEN_WIDTH-1:0]  fcol_q, fcol_d, orow_q, orow_d;
    logic [DATA_WIDTH-1:0] w_q, w_d, v_q, v_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  acc_valid_q, acc_valid_d, acc_last_q, acc_last_d;
    logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [LEN_WIDTH-1:0]  out_idx_q, out_idx_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [LEN_WIDTH-1:0]  m_last, n_last;
    logic                  active;

    assign m_last = m_q - LEN_WIDTH'(1);
    assign n_last = n_q - LEN_WIDTH'(1);
    // IP results are only honoured inside a layer, so anything still in flight
    // after a reset lands while IDLE and is dropped.
    assign active = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        m_d         = m_q;
        n_d         = n_q;
        row_d       = row_q;
        col_d       = col_q;
        fcol_d      = fcol_q;
        orow_d      = orow_q;
        w_d         = w_q;
        v_d         = v_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        acc_valid_d = 1'b0;
        acc_last_d  = 1'b0;
        acc_data_d  = acc_data_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;

        // Product forwarding. It runs independently of the FSM and relies on
        // the multiply IP returning results in issue order.
        if (active && bus.mul_res_valid) begin
            acc_valid_d = 1'b1;
            acc_data_d  = bus.mul_res;
            acc_last_d  = (fcol_q == m_last);
            fcol_d      = (fcol_q == m_last) ? '0 : fcol_q + LEN_WIDTH'(1);
        end

        // Row results. Partial sums without tlast are ignored.
        if (active && bus.acc_res_valid && bus.acc_res_last) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.acc_res;
            out_idx_d   = orow_q;
            orow_d      = orow_q + LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    m_d     = bus.in_len;
                    n_d     = bus.out_len;
                    row_d   = '0;
                    col_d   = '0;
                    fcol_d  = '0;
                    orow_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.in_len == '0 || bus.out_len == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (bus.rd_valid) begin
                    w_d     = bus.rd_data;
                    v_d     = bus.vec_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (col_q == m_last) begin
                    col_d   = '0;
                    row_d   = row_q + LEN_WIDTH'(1);
                    state_d = (row_q == n_last) ? DRAIN : FETCH;
                end else begin
                    col_d   = col_q + LEN_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            // orow_d already includes a result captured this cycle, so FINISH
            // follows the last out_valid without an extra bubble.
            DRAIN: if (orow_d == n_q) state_d = FINISH;
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            m_q         <= '0;
            n_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            fcol_q      <= '0;
            orow_q      <= '0;
            w_q         <= '0;
            v_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            m_q         <= m_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fcol_q      <= fcol_d;
            orow_q      <= orow_d;
            w_q         <= w_d;
            v_q         <= v_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_valid_q <= acc_valid_d;
            acc_last_q  <= acc_last_d;
            acc_data_q  <= acc_data_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    // rd_addr depends only on flops that hold still in FETCH, so it is stable
    // while rd_req is high. It wraps modulo 2^ADDR_WIDTH.
    assign bus.rd_req    = (state_q == FETCH);
    assign bus.rd_addr   = base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(m_q) + ADDR_WIDTH'(col_q);
    assign bus.vec_idx   = col_q;
    assign bus.mul_valid = (state_q == ISSUE);
    assign bus.mul_a     = w_q;
    assign bus.mul_b     = v_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_data  = acc_data_q;
    assign bus.acc_last  = acc_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
endmodule
